// File: rtl/unidad_control_id_pkg.sv
// unidad_control_pkg: opcodes, field positions and the control bundle
// shared by the ID control unit and the pipeline registers it feeds.
package unidad_control_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_VADD  = 4'h1;
  localparam logic [3:0] OP_VSUB  = 4'h2;
  localparam logic [3:0] OP_VMUL  = 4'h3;
  localparam logic [3:0] OP_SADD  = 4'h4;
  localparam logic [3:0] OP_SSUB  = 4'h5;
  localparam logic [3:0] OP_SMUL  = 4'h6;
  localparam logic [3:0] OP_VSADD = 4'h7;
  localparam logic [3:0] OP_VLD   = 4'h8;
  localparam logic [3:0] OP_VST   = 4'h9;
  localparam logic [3:0] OP_SLD   = 4'hA;
  localparam logic [3:0] OP_SST   = 4'hB;
  localparam logic [3:0] OP_SADDI = 4'hC;

  localparam logic [1:0] SV_VV  = 2'b00;
  localparam logic [1:0] SV_VS  = 2'b01;
  localparam logic [1:0] SV_SS  = 2'b10;
  localparam logic [1:0] SV_MEM = 2'b11;

  localparam int INSTR_W = 14;
  localparam int OP_MSB  = 13;
  localparam int OP_LSB  = 10;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 6;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 1;

  typedef struct packed {
    logic       reg_rdv;
    logic       reg_rds;
    logic       sel_dest;
    logic       sel_op;
    logic       sel_int;
    logic [1:0] sel_vec;
    logic [3:0] opcode;
    logic       sum_mem;
    logic       sel_mem;
    logic       sel_data;
    logic       mem_wr;
    logic       sel_wb;
    logic       reg_wrv;
    logic       reg_wrs;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    logic rs1_s;
    logic rs1_v;
    logic rs2_s;
    logic rs2_v;
  } src_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return op > OP_SADDI;
  endfunction
endpackage

// File: rtl/unidad_control_id_if.sv
// unidad_control_id_if: fetch-side handshake plus the control bundle
// presented to the EXE/MEM/WB pipeline registers.
interface unidad_control_id_if;
  logic        instr_valid_in;
  logic [13:0] instruction_in;
  logic        flush_in;
  logic        stall_out;
  logic        illegal_out;
  logic [13:0] instruction_out;
  logic        reg_rdv;
  logic        reg_rds;
  logic        sel_dest;
  logic        sel_op;
  logic        sel_int;
  logic [1:0]  sel_vec;
  logic [3:0]  opcode;
  logic        sum_mem;
  logic        sel_mem;
  logic        sel_data;
  logic        mem_wr;
  logic        sel_wb;
  logic        reg_wrv;
  logic        reg_wrs;

  modport master (
    output instr_valid_in, instruction_in, flush_in,
    input  stall_out, illegal_out, instruction_out, reg_rdv, reg_rds, sel_dest,
           sel_op, sel_int, sel_vec, opcode, sum_mem, sel_mem, sel_data, mem_wr,
           sel_wb, reg_wrv, reg_wrs
  );

  modport slave (
    input  instr_valid_in, instruction_in, flush_in,
    output stall_out, illegal_out, instruction_out, reg_rdv, reg_rds, sel_dest,
           sel_op, sel_int, sel_vec, opcode, sum_mem, sel_mem, sel_data, mem_wr,
           sel_wb, reg_wrv, reg_wrs
  );
endinterface

// File: rtl/marcador_registros.sv
// marcador_registros: per-register pending-write down-counters for one
// register file; a register is pending while its counter is nonzero.
module marcador_registros #(
  parameter int WB_LAT = 3,
  parameter int NREG = 8,
  localparam int IW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [IW-1:0]   idx,
  output logic [NREG-1:0] pending
);
  // The issue cycle is the first of the WB_LAT cycles, so only WB_LAT-1 remain to block readers.
  localparam logic [1:0] LOAD = 2'(WB_LAT - 1);
  logic [1:0] cnt_d [NREG];
  logic [1:0] cnt_q [NREG];
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = (load && idx == IW'(i)) ? LOAD : (cnt_q[i] != 2'd0 ? cnt_q[i] - 2'd1 : 2'd0);
      pending[i] = cnt_q[i] != 2'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/unidad_control_id.sv
// unidad_control_id: ID-stage decode, RAW scoreboard and stall/bubble
// insertion in front of the EXE/MEM/WB pipeline register.
module unidad_control_id
  import unidad_control_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int NREG = 8
) (
  input logic clk,
  input logic rst_n,
  unidad_control_id_if.slave bus
);
  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    c.opcode = op;
    case (op)
      OP_VADD, OP_VSUB, OP_VMUL: begin
        c.reg_rdv = 1'b1; c.sel_dest = 1'b1; c.reg_wrv = 1'b1; c.sel_vec = SV_VV;
      end
      OP_SADD, OP_SSUB, OP_SMUL: begin
        c.reg_rds = 1'b1; c.reg_wrs = 1'b1; c.sel_vec = SV_SS;
      end
      OP_VSADD: begin
        c.reg_rdv = 1'b1; c.reg_rds = 1'b1; c.sel_dest = 1'b1; c.reg_wrv = 1'b1; c.sel_vec = SV_VS;
      end
      OP_SADDI: begin
        c.reg_rds = 1'b1; c.sel_op = 1'b1; c.reg_wrs = 1'b1; c.sel_vec = SV_SS;
      end
      OP_VLD: begin
        c.sum_mem = 1'b1; c.sel_vec = SV_MEM; c.reg_rds = 1'b1; c.sel_wb = 1'b1;
        c.sel_mem = 1'b1; c.sel_dest = 1'b1; c.reg_wrv = 1'b1;
      end
      OP_VST: begin
        c.sum_mem = 1'b1; c.sel_vec = SV_MEM; c.reg_rds = 1'b1; c.mem_wr = 1'b1;
        c.sel_mem = 1'b1; c.sel_data = 1'b1; c.reg_rdv = 1'b1;
      end
      OP_SLD: begin
        c.sum_mem = 1'b1; c.sel_vec = SV_MEM; c.reg_rds = 1'b1; c.sel_wb = 1'b1; c.reg_wrs = 1'b1;
      end
      OP_SST: begin
        c.sum_mem = 1'b1; c.sel_vec = SV_MEM; c.reg_rds = 1'b1; c.mem_wr = 1'b1;
      end
      default: c = '0;
    endcase
    c.sel_int = (op == OP_VMUL) || (op == OP_SMUL);
    return c;
  endfunction

  function automatic src_t sources(input logic [3:0] op);
    src_t s;
    s.rs1_v = op inside {OP_VADD, OP_VSUB, OP_VMUL, OP_VSADD};
    s.rs1_s = op inside {OP_SADD, OP_SSUB, OP_SMUL, OP_SADDI, OP_VLD, OP_VST, OP_SLD, OP_SST};
    s.rs2_v = op inside {OP_VADD, OP_VSUB, OP_VMUL, OP_VST};
    s.rs2_s = op inside {OP_SADD, OP_SSUB, OP_SMUL, OP_VSADD, OP_SST};
    return s;
  endfunction

  logic [3:0]         op;
  logic [2:0]         rd, rs1, rs2;
  logic [NREG-1:0]    pend_s, pend_v;
  src_t               src;
  ctrl_t              dec, ctrl_d, ctrl_q;
  logic               raw, live, go, illegal_d, illegal_q;
  logic [INSTR_W-1:0] instr_d, instr_q;

  always_comb begin
    op = bus.instruction_in[OP_MSB:OP_LSB];
    rd = bus.instruction_in[RD_MSB:RD_LSB];
    rs1 = bus.instruction_in[RS1_MSB:RS1_LSB];
    rs2 = bus.instruction_in[RS2_MSB:RS2_LSB];
    dec = decode(op);
    src = sources(op);
    raw = (src.rs1_s & pend_s[rs1]) | (src.rs1_v & pend_v[rs1]) |
          (src.rs2_s & pend_s[rs2]) | (src.rs2_v & pend_v[rs2]);
    live = bus.instr_valid_in & ~bus.flush_in;
    go = live & ~raw;
    ctrl_d = go ? dec : '0;
    instr_d = go ? bus.instruction_in : '0;
    illegal_d = go & is_reserved(op);
  end

  assign bus.stall_out = live & raw;

  marcador_registros #(.WB_LAT(WB_LAT), .NREG(NREG)) u_sb_s (
    .clk(clk), .rst_n(rst_n), .load(go & dec.reg_wrs), .idx(rd), .pending(pend_s)
  );

  marcador_registros #(.WB_LAT(WB_LAT), .NREG(NREG)) u_sb_v (
    .clk(clk), .rst_n(rst_n), .load(go & dec.reg_wrv), .idx(rd), .pending(pend_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      instr_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      instr_q <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal_out = illegal_q;
  assign bus.instruction_out = instr_q;
  assign bus.reg_rdv = ctrl_q.reg_rdv;
  assign bus.reg_rds = ctrl_q.reg_rds;
  assign bus.sel_dest = ctrl_q.sel_dest;
  assign bus.sel_op = ctrl_q.sel_op;
  assign bus.sel_int = ctrl_q.sel_int;
  assign bus.sel_vec = ctrl_q.sel_vec;
  assign bus.opcode = ctrl_q.opcode;
  assign bus.sum_mem = ctrl_q.sum_mem;
  assign bus.sel_mem = ctrl_q.sel_mem;
  assign bus.sel_data = ctrl_q.sel_data;
  assign bus.mem_wr = ctrl_q.mem_wr;
  assign bus.sel_wb = ctrl_q.sel_wb;
  assign bus.reg_wrv = ctrl_q.reg_wrv;
  assign bus.reg_wrs = ctrl_q.reg_wrs;
endmodule

// File: tb/tb_unidad_control_id.sv
// tb_unidad_control_id: directed and random stimulus against a cycle-indexed
// reference model of decode and RAW readiness.
module tb_unidad_control_id;
  localparam int WB_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unidad_control_id_if b ();
  unidad_control_id #(.WB_LAT(WB_LAT), .NREG(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {b.reg_rdv, b.reg_rds, b.sel_dest, b.sel_op, b.sel_int, b.sel_vec, b.opcode,
                     b.sum_mem, b.sel_mem, b.sel_data, b.mem_wr, b.sel_wb, b.reg_wrv, b.reg_wrs};

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  int free_s [8];
  int free_v [8];
  logic dut_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] model_ctrl(input logic [3:0] op);
    bit v, s, vs, imm, mem, st, ld;
    v = op >= 1 && op <= 3;
    s = op >= 4 && op <= 6;
    vs = op == 7;
    imm = op == 12;
    mem = op >= 8 && op <= 11;
    ld = op == 8 || op == 10;
    st = op == 9 || op == 11;
    return {v | vs | op == 9, s | vs | imm | mem, v | vs | op == 8, imm, op == 3 || op == 6,
            mem ? 2'b11 : (s | imm) ? 2'b10 : vs ? 2'b01 : 2'b00,
            op <= 12 ? op : 4'h0,
            mem, op == 8 || op == 9, op == 9, st, ld, v | vs | op == 8, s | imm | op == 10};
  endfunction

  function automatic bit model_raw(input logic [13:0] ins);
    logic [3:0] op;
    int r1, r2;
    op = ins[13:10];
    r1 = int'(ins[6:4]);
    r2 = int'(ins[3:1]);
    return ((op inside {[1:3], 7}) && free_v[r1] > cyc) ||
           ((op inside {[4:6], [8:12]}) && free_s[r1] > cyc) ||
           ((op inside {[1:3], 9}) && free_v[r2] > cyc) ||
           ((op inside {[4:7], 11}) && free_s[r2] > cyc);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      free_s[i] = 0;
      free_v[i] = 0;
    end
  endtask

  task automatic step(input logic v, input logic [13:0] ins, input logic fl);
    logic [3:0] op;
    logic [17:0] ec;
    bit raw, iss;
    b.instr_valid_in = v;
    b.instruction_in = ins;
    b.flush_in = fl;
    #1;
    op = ins[13:10];
    raw = model_raw(ins);
    iss = v && !fl && !raw;
    ec = model_ctrl(op);
    dut_stall = b.stall_out;
    chk("stall", 32'(b.stall_out), 32'(v && !fl && raw));
    @(posedge clk);
    #1;
    chk("ctrl", 32'(dut_ctrl), iss ? 32'(ec) : 32'd0);
    chk("instr_out", 32'(b.instruction_out), iss ? 32'(ins) : 32'd0);
    chk("illegal", 32'(b.illegal_out), 32'(iss && op >= 13));
    if (iss && ec[1]) free_v[ins[9:7]] = cyc + WB_LAT;
    if (iss && ec[0]) free_s[ins[9:7]] = cyc + WB_LAT;
    cyc++;
  endtask

  function automatic logic [13:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] r1, input logic [2:0] r2);
    return {op, rd, r1, r2, 1'b0};
  endfunction

  initial begin
    int n;
    logic [13:0] ins;
    logic v, fl, held;
    clear_model();
    b.instr_valid_in = 1'b0;
    b.instruction_in = '0;
    b.flush_in = 1'b0;
    #2;
    chk("rst_ctrl", 32'(dut_ctrl), 32'd0);
    chk("rst_instr", 32'(b.instruction_out), 32'd0);
    chk("rst_illegal", 32'(b.illegal_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // RAW: dependent scalar op stalls WB_LAT-1 cycles
    step(1'b1, mk(4'h4, 3'd1, 3'd2, 3'd3), 1'b0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(4'h4, 3'd4, 3'd1, 3'd1), 1'b0);
      if (!dut_stall) break;
      n++;
    end
    chk("raw_stalls", 32'(n), 32'(WB_LAT - 1));

    // independent vector ops back to back
    step(1'b1, mk(4'h1, 3'd2, 3'd0, 3'd1), 1'b0);
    step(1'b1, mk(4'h2, 3'd5, 3'd3, 3'd4), 1'b0);
    chk("indep_stall", 32'(dut_stall), 32'd0);

    // VST whose address register is pending from an SLD
    step(1'b1, mk(4'hA, 3'd5, 3'd0, 3'd0), 1'b0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(4'h9, 3'd0, 3'd5, 3'd6), 1'b0);
      if (!dut_stall) break;
      n++;
    end
    chk("mem_stalls", 32'(n), 32'(WB_LAT - 1));
    chk("vst_fields", 32'({b.sum_mem, b.sel_mem, b.sel_data, b.mem_wr, b.sel_vec}), 32'(6'b111111));

    // flush wins over hazard; scoreboard keeps counting down
    step(1'b1, mk(4'h4, 3'd6, 3'd0, 3'd0), 1'b0);
    step(1'b1, mk(4'h5, 3'd7, 3'd6, 3'd0), 1'b1);
    chk("flush_stall", 32'(dut_stall), 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(4'h5, 3'd7, 3'd6, 3'd0), 1'b0);
      if (!dut_stall) break;
      n++;
    end
    chk("post_flush_stalls", 32'(n), 32'(WB_LAT - 2));

    // reserved opcode: illegal for exactly one cycle
    step(1'b1, {4'hE, 3'd1, 3'd2, 3'd3, 1'b1}, 1'b0);
    chk("illegal_hi", 32'(b.illegal_out), 32'd1);
    step(1'b1, 14'h0, 1'b0);
    chk("illegal_lo", 32'(b.illegal_out), 32'd0);

    // reset mid-operation with a vector write still pending
    step(1'b1, mk(4'h1, 3'd2, 3'd0, 3'd1), 1'b0);
    b.instr_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'(dut_ctrl), 32'd0);
    chk("mid_rst_instr", 32'(b.instruction_out), 32'd0);
    clear_model();
    rst_n = 1'b1;
    step(1'b1, mk(4'h1, 3'd3, 3'd2, 3'd2), 1'b0);
    chk("post_rst_nostall", 32'(dut_stall), 32'd0);
    chk("post_rst_vadd", 32'({b.reg_rdv, b.sel_dest, b.reg_wrv, b.sel_vec}), 32'(5'b11100));

    // random traffic; fetch holds a stalled instruction
    held = 1'b0;
    ins = '0;
    v = 1'b0;
    fl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        ins = 14'($urandom);
        v = $urandom_range(0, 9) != 0;
      end
      fl = $urandom_range(0, 9) == 0;
      step(v, ins, fl);
      held = dut_stall;
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
